// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised inter-stage pipeline register placed between stage STAGE and
// stage STAGE+1. It carries the ALU control fields, both operands, the
// destination register, the instruction word and its PC. It also carries a
// valid bit, and it reports whether it held its contents on the last edge.
//
// Update priority on each rising clk edge, highest first:
//   rst > flush > bubble (upstream stalled, downstream running)
//       > load (upstream running) > hold (both stalled)
// When upstream is running and downstream is stalled (s_up=0, s_dn=1), the
// stall pattern is inconsistent. The register still loads, and the checker
// module at the end of this file flags the case.
//
// Optional build macro: IDEX_PERF_EN
//   When it is defined, saturating bubble and hold counters are built.
//   When it is undefined, no counter flops exist and both counter outputs are
//   constant 0.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stall             per-stage stall vector from the stall controller
//   flush             squash: kills the held and the incoming contents
//   in_*              upstream slot contents (valid, aluop, alusel, reg1,
//                     reg2, wd, wreg, inst, pc)
//   out_*             registered copies of in_*
//   out_hold          register held its contents on the previous edge
//   bubble_cnt        bubbles inserted over a valid slot (perf build only)
//   hold_cnt          hold cycles (perf build only)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int STALL_W  = 6,
    parameter int STAGE    = 2,
    parameter int NOP_OP   = 0,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [ALUOP_W-1:0]  in_aluop,
    input  logic [ALUSEL_W-1:0] in_alusel,
    input  logic [DATA_W-1:0]   in_reg1,
    input  logic [DATA_W-1:0]   in_reg2,
    input  logic [ADDR_W-1:0]   in_wd,
    input  logic                in_wreg,
    input  logic [DATA_W-1:0]   in_inst,
    input  logic [DATA_W-1:0]   in_pc,
    output logic                out_valid,
    output logic [ALUOP_W-1:0]  out_aluop,
    output logic [ALUSEL_W-1:0] out_alusel,
    output logic [DATA_W-1:0]   out_reg1,
    output logic [DATA_W-1:0]   out_reg2,
    output logic [ADDR_W-1:0]   out_wd,
    output logic                out_wreg,
    output logic [DATA_W-1:0]   out_inst,
    output logic [DATA_W-1:0]   out_pc,
    output logic                out_hold,
    output logic [CNT_W-1:0]    bubble_cnt,
    output logic [CNT_W-1:0]    hold_cnt
);

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_FLUSH  = 2'd3
    } act_t;

    logic w_s_up;
    logic w_s_dn;
    logic w_unused_stall;
    act_t w_act;

    assign w_s_up = stall[STAGE];
    assign w_s_dn = stall[STAGE+1];
    // This register only looks at its own two stall bits.
    assign w_unused_stall = ^stall;

    // Decode this edge's action from flush and the two relevant stall bits.
    always_comb begin
        w_act = ACT_LOAD;
        if (flush) begin
            w_act = ACT_FLUSH;
        end else if (w_s_up && !w_s_dn) begin
            w_act = ACT_BUBBLE;
        end else if (!w_s_up) begin
            // Includes the inconsistent s_up=0/s_dn=1 pattern.
            w_act = ACT_LOAD;
        end else begin
            w_act = ACT_HOLD;
        end
    end

    // Payload, valid and hold-flag register.
    always_ff @(posedge clk) begin
        if (rst || (w_act == ACT_FLUSH) || (w_act == ACT_BUBBLE)) begin
            out_valid  <= 1'b0;
            out_aluop  <= ALUOP_W'(NOP_OP);
            out_alusel <= {ALUSEL_W{1'b0}};
            out_reg1   <= {DATA_W{1'b0}};
            out_reg2   <= {DATA_W{1'b0}};
            out_wd     <= {ADDR_W{1'b0}};
            out_wreg   <= 1'b0;
            out_inst   <= {DATA_W{1'b0}};
            out_pc     <= {DATA_W{1'b0}};
            out_hold   <= 1'b0;
        end else if (w_act == ACT_LOAD) begin
            out_valid  <= in_valid;
            out_aluop  <= in_aluop;
            out_alusel <= in_alusel;
            out_reg1   <= in_reg1;
            out_reg2   <= in_reg2;
            out_wd     <= in_wd;
            // An empty slot must never produce a register-file write later on.
            out_wreg   <= in_wreg & in_valid;
            out_inst   <= in_inst;
            out_pc     <= in_pc;
            out_hold   <= 1'b0;
        end else begin
            out_hold   <= 1'b1;
        end
    end

`ifdef IDEX_PERF_EN
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_hold_cnt;

    // Saturating perf counters; flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= {CNT_W{1'b0}};
            r_hold_cnt   <= {CNT_W{1'b0}};
        end else begin
            // A bubble counts only when it displaces a live instruction.
            if ((w_act == ACT_BUBBLE) && out_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end else begin
                r_bubble_cnt <= r_bubble_cnt;
            end
            if ((w_act == ACT_HOLD) && (r_hold_cnt != {CNT_W{1'b1}})) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end else begin
                r_hold_cnt <= r_hold_cnt;
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign hold_cnt   = r_hold_cnt;
`else
    assign bubble_cnt = {CNT_W{1'b0}};
    assign hold_cnt   = {CNT_W{1'b0}};
`endif

    pipe_stage_reg_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .s_up (w_s_up),
        .s_dn (w_s_dn)
    );

endmodule

// ---------------------------------------------------------------------------
// pipe_stage_reg_chk
//
// Property checker: the downstream stage must never stall while the upstream
// stage keeps running.
//
// Ports: clk, rst, s_up (upstream stall bit), s_dn (downstream stall bit)
// ---------------------------------------------------------------------------
module pipe_stage_reg_chk (
    input logic clk,
    input logic rst,
    input logic s_up,
    input logic s_dn
);

    a_legal_stall: assert property (@(posedge clk) disable iff (rst) !(!s_up && s_dn))
        else $error("pipe_stage_reg: inconsistent stall pattern s_up=0 s_dn=1");

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int CW = 2;

`ifdef IDEX_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic          valid;
        logic [7:0]    aluop;
        logic [2:0]    alusel;
        logic [31:0]   reg1;
        logic [31:0]   reg2;
        logic [4:0]    wd;
        logic          wreg;
        logic [31:0]   inst;
        logic [31:0]   pc;
        logic          hold;
        logic [CW-1:0] bcnt;
        logic [CW-1:0] hcnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_aluop;
    logic [2:0]  in_alusel;
    logic [31:0] in_reg1;
    logic [31:0] in_reg2;
    logic [4:0]  in_wd;
    logic        in_wreg;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic [7:0]  out_aluop;
    logic [2:0]  out_alusel;
    logic [31:0] out_reg1;
    logic [31:0] out_reg2;
    logic [4:0]  out_wd;
    logic        out_wreg;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_hold;
    logic [CW-1:0] bubble_cnt;
    logic [CW-1:0] hold_cnt;

    int   total;
    int   bad;
    exp_t m;
    exp_t exp_q[$];

    pipe_stage_reg #(
        .DATA_W(32), .ADDR_W(5), .ALUOP_W(8), .ALUSEL_W(3),
        .STALL_W(6), .STAGE(2), .NOP_OP(0), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_aluop(in_aluop), .in_alusel(in_alusel),
        .in_reg1(in_reg1), .in_reg2(in_reg2), .in_wd(in_wd),
        .in_wreg(in_wreg), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_aluop(out_aluop), .out_alusel(out_alusel),
        .out_reg1(out_reg1), .out_reg2(out_reg2), .out_wd(out_wd),
        .out_wreg(out_wreg), .out_inst(out_inst), .out_pc(out_pc),
        .out_hold(out_hold), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t clear_fields(input exp_t s);
        exp_t r;
        r        = s;
        r.valid  = 1'b0;
        r.aluop  = 8'h00;
        r.alusel = 3'd0;
        r.reg1   = 32'h0;
        r.reg2   = 32'h0;
        r.wd     = 5'd0;
        r.wreg   = 1'b0;
        r.inst   = 32'h0;
        r.pc     = 32'h0;
        r.hold   = 1'b0;
        return r;
    endfunction

    // Reference model: compute the post-edge state from the current inputs
    // and the model state, queue it, then compare after the edge.
    task automatic step(input string tag);
        exp_t e;
        logic s_up;
        logic s_dn;
        s_up = stall[2];
        s_dn = stall[3];
        if (rst) begin
            m = clear_fields(m);
            m.bcnt = '0;
            m.hcnt = '0;
        end else if (flush) begin
            m = clear_fields(m);
        end else if (s_up && !s_dn) begin
            if (PERF && m.valid && (m.bcnt != {CW{1'b1}})) m.bcnt = m.bcnt + 1'b1;
            m = clear_fields(m);
        end else if (!s_up) begin
            m.valid  = in_valid;
            m.aluop  = in_aluop;
            m.alusel = in_alusel;
            m.reg1   = in_reg1;
            m.reg2   = in_reg2;
            m.wd     = in_wd;
            m.wreg   = in_wreg & in_valid;
            m.inst   = in_inst;
            m.pc     = in_pc;
            m.hold   = 1'b0;
        end else begin
            m.hold = 1'b1;
            if (PERF && (m.hcnt != {CW{1'b1}})) m.hcnt = m.hcnt + 1'b1;
        end
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ":queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ":valid"},  32'(out_valid),  32'(e.valid));
            chk({tag, ":aluop"},  32'(out_aluop),  32'(e.aluop));
            chk({tag, ":alusel"}, 32'(out_alusel), 32'(e.alusel));
            chk({tag, ":reg1"},   out_reg1,        e.reg1);
            chk({tag, ":reg2"},   out_reg2,        e.reg2);
            chk({tag, ":wd"},     32'(out_wd),     32'(e.wd));
            chk({tag, ":wreg"},   32'(out_wreg),   32'(e.wreg));
            chk({tag, ":inst"},   out_inst,        e.inst);
            chk({tag, ":pc"},     out_pc,          e.pc);
            chk({tag, ":hold"},   32'(out_hold),   32'(e.hold));
            chk({tag, ":bcnt"},   32'(bubble_cnt), 32'(e.bcnt));
            chk({tag, ":hcnt"},   32'(hold_cnt),   32'(e.hcnt));
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd,
                         input logic we, input logic [31:0] inst, input logic [31:0] pc);
        in_valid  = v;
        in_aluop  = op;
        in_alusel = sel;
        in_reg1   = r1;
        in_reg2   = r2;
        in_wd     = wd;
        in_wreg   = we;
        in_inst   = inst;
        in_pc     = pc;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m     = clear_fields(m);
        m.bcnt = '0;
        m.hcnt = '0;

        // Reset with a live instruction on the inputs.
        rst   = 1'b1;
        flush = 1'b0;
        stall = 6'b000000;
        drive(1'b1, 8'h21, 3'd5, 32'hAAAA_5555, 32'h5555_AAAA, 5'd3, 1'b1, 32'hFFFF_0000, 32'h0000_0100);
        step("rst0");
        step("rst1");

        // Plain load.
        rst = 1'b0;
        drive(1'b1, 8'h21, 3'd2, 32'h1234_5678, 32'h0BAD_F00D, 5'd7, 1'b1, 32'hDEAD_BEEF, 32'h0000_0040);
        step("load");

        // Bubble over a valid slot, then over an empty one.
        stall = 6'b000111;
        step("bubble");
        step("bubble_empty");

        // Load, then hold three cycles.
        stall = 6'b000000;
        drive(1'b1, 8'h05, 3'd1, 32'h0000_0011, 32'h0000_0022, 5'd9, 1'b1, 32'h2001_0005, 32'h0000_0044);
        step("load_hold");
        stall = 6'b001111;
        drive(1'b1, 8'h77, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1, 32'h1111_1111, 32'h0000_0048);
        step("hold1");
        step("hold2");
        step("hold3");

        // Flush beats hold.
        flush = 1'b1;
        step("flush_hold");
        flush = 1'b0;

        // Empty slot carrying a write enable.
        stall = 6'b000000;
        drive(1'b0, 8'h33, 3'd4, 32'hCAFE_0001, 32'hCAFE_0002, 5'd12, 1'b1, 32'h0000_0013, 32'h0000_004C);
        step("inval_wreg");

        // Back-to-back loads with varied payloads.
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom), $urandom, $urandom,
                  5'($urandom), 1'($urandom_range(0, 1)), $urandom, 32'h0000_0100 + 32'(i * 4));
            step("load_rand");
        end

        // Reset during a hold.
        stall = 6'b001111;
        step("hold_pre_rst");
        rst = 1'b1;
        step("rst_in_hold");
        rst = 1'b0;

        // Counter saturation: five holds, then alternating load/bubble.
        stall = 6'b000000;
        drive(1'b1, 8'h44, 3'd3, 32'h0000_00AA, 32'h0000_00BB, 5'd1, 1'b1, 32'h0000_0AAA, 32'h0000_0200);
        step("load_sat");
        stall = 6'b001111;
        for (int i = 0; i < 5; i++) step("hold_sat");
        for (int i = 0; i < 4; i++) begin
            stall = 6'b000000;
            step("load_bsat");
            stall = 6'b000111;
            step("bubble_sat");
        end

        // Counters survive a flush.
        stall = 6'b000000;
        flush = 1'b1;
        step("flush_keep_cnt");
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
